// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX pipeline register and its hazard unit.
package id_ex_stage_pkg;

  localparam int REG_W = 5;

  // ALU B operand select encodings seen by the execute stage.
  localparam logic [1:0] ALU_B_REG   = 2'd0;
  localparam logic [1:0] ALU_B_IMM   = 2'd1;
  localparam logic [1:0] ALU_B_EIGHT = 2'd2;
  localparam logic [1:0] ALU_B_TEN   = 2'd3;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef struct packed {
    logic        valid;
    logic        reg_dst;
    logic        alu_src0;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  alu_src1;
    logic [4:0]  shamt;
    reg_idx_t    rt;
    reg_idx_t    rd;
    logic [31:0] reg_data1;
    logic [31:0] reg_data2;
    logic [31:0] imm32b;
    logic [31:0] pc_plus_four;
    logic [5:0]  funct;
    logic [5:0]  opcode;
    logic [25:0] instr_index;
  } ex_fields_t;

  // A bubble is an all-zero slot so nothing undefined leaks into execute.
  localparam ex_fields_t BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side inputs, execute-side outputs and hazard status of the ID/EX stage.
interface id_ex_stage_if #(parameter int CNT_W = 32);
  import id_ex_stage_pkg::*;

  logic        id_valid;
  logic        id_reg_dst;
  logic        id_alu_src0;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic [1:0]  id_alu_src1;
  logic [4:0]  id_shamt;
  reg_idx_t    id_rs;
  reg_idx_t    id_rt;
  reg_idx_t    id_rd;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic [31:0] id_reg_data1;
  logic [31:0] id_reg_data2;
  logic [31:0] id_imm32b;
  logic [31:0] id_pc_plus_four;
  logic [5:0]  id_funct;
  logic [5:0]  id_opcode;
  logic [25:0] id_instr_index;

  logic        mem_reg_write;
  reg_idx_t    mem_dest;
  logic        flush;
  logic        hold;

  logic        ex_valid;
  logic        ex_reg_dst;
  logic        ex_alu_src0;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [1:0]  ex_alu_src1;
  logic [4:0]  ex_shamt;
  reg_idx_t    ex_rt;
  reg_idx_t    ex_rd;
  logic [31:0] ex_reg_data1;
  logic [31:0] ex_reg_data2;
  logic [31:0] ex_imm32b;
  logic [31:0] ex_pc_plus_four;
  logic [5:0]  ex_funct;
  logic [5:0]  ex_opcode;
  logic [25:0] ex_instr_index;

  logic             stall;
  logic [CNT_W-1:0] bubble_count;

  modport master (
    output id_valid, id_reg_dst, id_alu_src0, id_reg_write, id_mem_read, id_mem_write,
           id_alu_src1, id_shamt, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
           id_reg_data1, id_reg_data2, id_imm32b, id_pc_plus_four, id_funct, id_opcode,
           id_instr_index, mem_reg_write, mem_dest, flush, hold,
    input  ex_valid, ex_reg_dst, ex_alu_src0, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_alu_src1, ex_shamt, ex_rt, ex_rd, ex_reg_data1, ex_reg_data2, ex_imm32b,
           ex_pc_plus_four, ex_funct, ex_opcode, ex_instr_index, stall, bubble_count
  );

  modport slave (
    input  id_valid, id_reg_dst, id_alu_src0, id_reg_write, id_mem_read, id_mem_write,
           id_alu_src1, id_shamt, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
           id_reg_data1, id_reg_data2, id_imm32b, id_pc_plus_four, id_funct, id_opcode,
           id_instr_index, mem_reg_write, mem_dest, flush, hold,
    output ex_valid, ex_reg_dst, ex_alu_src0, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_alu_src1, ex_shamt, ex_rt, ex_rd, ex_reg_data1, ex_reg_data2, ex_imm32b,
           ex_pc_plus_four, ex_funct, ex_opcode, ex_instr_index, stall, bubble_count
  );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational RAW / load-use detector comparing ID sources against EX and MEM writers.
module id_ex_stage_hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter bit FORWARDING = 1'b1
) (
  input  reg_idx_t id_rs,
  input  reg_idx_t id_rt,
  input  logic     id_uses_rs,
  input  logic     id_uses_rt,
  input  logic     ex_valid,
  input  logic     ex_reg_write,
  input  logic     ex_mem_read,
  input  reg_idx_t ex_dest,
  input  reg_idx_t ex_rt,
  input  logic     mem_reg_write,
  input  reg_idx_t mem_dest,
  output logic     hazard
);

  // $0 is hard-wired, so a write to it can never feed a reader.
  function automatic logic src_hit(input reg_idx_t d, input reg_idx_t rs, input reg_idx_t rt,
                                   input logic uses_rs, input logic uses_rt);
    return (d != '0) && ((uses_rs && d == rs) || (uses_rt && d == rt));
  endfunction

  logic load_use;
  logic raw_ex;
  logic raw_mem;

  always_comb begin
    load_use = ex_valid && ex_mem_read && src_hit(ex_rt, id_rs, id_rt, id_uses_rs, id_uses_rt);
    raw_ex   = ex_valid && ex_reg_write && src_hit(ex_dest, id_rs, id_rt, id_uses_rs, id_uses_rt);
    raw_mem  = mem_reg_write && src_hit(mem_dest, id_rs, id_rt, id_uses_rs, id_uses_rt);
    hazard   = FORWARDING ? load_use : (load_use || raw_ex || raw_mem);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decode fields, inserts bubbles on hazards and flushes,
// and counts hazard bubbles with a saturating counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter bit FORWARDING = 1'b1,
  parameter int CNT_W      = 32
) (
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  ex_fields_t       ex_q;
  ex_fields_t       id_fields;
  logic [CNT_W-1:0] bubble_q;
  reg_idx_t         ex_dest;
  logic             hazard;
  logic             stall;

  always_comb begin
    id_fields              = BUBBLE;
    id_fields.valid        = bus.id_valid;
    id_fields.reg_dst      = bus.id_reg_dst;
    id_fields.alu_src0     = bus.id_alu_src0;
    id_fields.reg_write    = bus.id_reg_write;
    id_fields.mem_read     = bus.id_mem_read;
    id_fields.mem_write    = bus.id_mem_write;
    id_fields.alu_src1     = bus.id_alu_src1;
    id_fields.shamt        = bus.id_shamt;
    id_fields.rt           = bus.id_rt;
    id_fields.rd           = bus.id_rd;
    id_fields.reg_data1    = bus.id_reg_data1;
    id_fields.reg_data2    = bus.id_reg_data2;
    id_fields.imm32b       = bus.id_imm32b;
    id_fields.pc_plus_four = bus.id_pc_plus_four;
    id_fields.funct        = bus.id_funct;
    id_fields.opcode       = bus.id_opcode;
    id_fields.instr_index  = bus.id_instr_index;
  end

  // Same destination select the execute stage uses: RegDst=0 writes rt.
  assign ex_dest = ex_q.reg_dst ? ex_q.rd : ex_q.rt;

  id_ex_stage_hazard_detect #(.FORWARDING(FORWARDING)) u_hazard (
    .id_rs         (bus.id_rs),
    .id_rt         (bus.id_rt),
    .id_uses_rs    (bus.id_uses_rs),
    .id_uses_rt    (bus.id_uses_rt),
    .ex_valid      (ex_q.valid),
    .ex_reg_write  (ex_q.reg_write),
    .ex_mem_read   (ex_q.mem_read),
    .ex_dest       (ex_dest),
    .ex_rt         (ex_q.rt),
    .mem_reg_write (bus.mem_reg_write),
    .mem_dest      (bus.mem_dest),
    .hazard        (hazard)
  );

  assign stall = bus.id_valid && hazard && !bus.flush && !rst;

  // Flush beats hold, which beats a hazard bubble; only hazard bubbles are counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q     <= BUBBLE;
      bubble_q <= '0;
    end else if (bus.flush) begin
      ex_q <= BUBBLE;
    end else if (bus.hold) begin
      ex_q     <= ex_q;
      bubble_q <= bubble_q;
    end else if (stall) begin
      ex_q <= BUBBLE;
      if (!(&bubble_q)) bubble_q <= bubble_q + CNT_ONE;
    end else begin
      ex_q <= id_fields;
    end
  end

  assign bus.ex_valid        = ex_q.valid;
  assign bus.ex_reg_dst      = ex_q.reg_dst;
  assign bus.ex_alu_src0     = ex_q.alu_src0;
  assign bus.ex_reg_write    = ex_q.reg_write;
  assign bus.ex_mem_read     = ex_q.mem_read;
  assign bus.ex_mem_write    = ex_q.mem_write;
  assign bus.ex_alu_src1     = ex_q.alu_src1;
  assign bus.ex_shamt        = ex_q.shamt;
  assign bus.ex_rt           = ex_q.rt;
  assign bus.ex_rd           = ex_q.rd;
  assign bus.ex_reg_data1    = ex_q.reg_data1;
  assign bus.ex_reg_data2    = ex_q.reg_data2;
  assign bus.ex_imm32b       = ex_q.imm32b;
  assign bus.ex_pc_plus_four = ex_q.pc_plus_four;
  assign bus.ex_funct        = ex_q.funct;
  assign bus.ex_opcode       = ex_q.opcode;
  assign bus.ex_instr_index  = ex_q.instr_index;
  assign bus.stall           = stall;
  assign bus.bubble_count    = bubble_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench: one forwarding instance (4-bit counter) and one non-forwarding instance.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.CNT_W(4))  b1 ();
  id_ex_stage_if #(.CNT_W(32)) b0 ();

  id_ex_stage #(.FORWARDING(1'b1), .CNT_W(4))  dut1 (.clk(clk), .rst(rst), .bus(b1));
  id_ex_stage #(.FORWARDING(1'b0), .CNT_W(32)) dut0 (.clk(clk), .rst(rst), .bus(b0));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic instr1(input logic v, input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic urs, input logic urt, input logic rdst,
                        input logic rw, input logic mr);
    b1.id_valid = v;   b1.id_opcode = op; b1.id_funct = fn;
    b1.id_rs = rs;     b1.id_rt = rt;     b1.id_rd = rd;
    b1.id_uses_rs = urs; b1.id_uses_rt = urt; b1.id_reg_dst = rdst;
    b1.id_reg_write = rw; b1.id_mem_read = mr; b1.id_mem_write = 1'b0;
    b1.id_alu_src0 = 1'b0; b1.id_alu_src1 = ALU_B_REG; b1.id_shamt = '0;
    b1.id_reg_data1 = '0; b1.id_reg_data2 = '0; b1.id_imm32b = '0;
    b1.id_pc_plus_four = '0; b1.id_instr_index = '0;
  endtask

  task automatic instr0(input logic v, input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic urs, input logic urt, input logic rdst,
                        input logic rw, input logic mr);
    b0.id_valid = v;   b0.id_opcode = op; b0.id_funct = fn;
    b0.id_rs = rs;     b0.id_rt = rt;     b0.id_rd = rd;
    b0.id_uses_rs = urs; b0.id_uses_rt = urt; b0.id_reg_dst = rdst;
    b0.id_reg_write = rw; b0.id_mem_read = mr; b0.id_mem_write = 1'b0;
    b0.id_alu_src0 = 1'b0; b0.id_alu_src1 = ALU_B_REG; b0.id_shamt = '0;
    b0.id_reg_data1 = '0; b0.id_reg_data2 = '0; b0.id_imm32b = '0;
    b0.id_pc_plus_four = '0; b0.id_instr_index = '0;
  endtask

  initial begin
    b1.flush = 1'b0; b1.hold = 1'b0; b1.mem_reg_write = 1'b0; b1.mem_dest = '0;
    b0.flush = 1'b0; b0.hold = 1'b0; b0.mem_reg_write = 1'b0; b0.mem_dest = '0;

    // Reset with every decode field non-zero.
    instr1(1, 6'h3f, 6'h3f, 5'd31, 5'd31, 5'd31, 1, 1, 1, 1, 1);
    b1.id_mem_write = 1; b1.id_alu_src0 = 1; b1.id_alu_src1 = ALU_B_TEN; b1.id_shamt = 5'd31;
    b1.id_reg_data1 = 32'hdeadbeef; b1.id_reg_data2 = 32'h12345678; b1.id_imm32b = 32'hffff;
    b1.id_pc_plus_four = 32'h404; b1.id_instr_index = 26'h3ffffff;
    instr0(1, 6'h2b, 6'h22, 5'd7, 5'd9, 5'd9, 1, 1, 1, 1, 0);
    b0.id_imm32b = 32'h55;
    rst = 1'b1;
    #1;
    chk("stall_in_reset", b1.stall, 1'b0);
    tick();
    tick();
    chk("rst_ex_valid", b1.ex_valid, 1'b0);
    chk("rst_ex_opcode", b1.ex_opcode, 6'h0);
    chk("rst_ex_reg_data1", b1.ex_reg_data1, 32'h0);
    chk("rst_ex_instr_index", b1.ex_instr_index, 26'h0);
    chk("rst_ex_alu_src1", b1.ex_alu_src1, ALU_B_REG);
    chk("rst_ex_mem_write", b1.ex_mem_write, 1'b0);
    chk("rst_bubble_count", b1.bubble_count, 4'h0);
    chk("rst_stall", b1.stall, 1'b0);
    chk("rst_ex_imm_b0", b0.ex_imm32b, 32'h0);
    chk("rst_bubble_count_b0", b0.bubble_count, 32'h0);

    // First capture after release.
    rst = 1'b0;
    instr1(1, 6'h08, 6'h00, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
    b1.id_imm32b = 32'h10; b1.id_alu_src1 = ALU_B_IMM;
    instr0(0, 6'h0, 6'h0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    tick();
    chk("first_ex_opcode", b1.ex_opcode, 6'h08);
    chk("first_ex_imm", b1.ex_imm32b, 32'h10);
    chk("first_ex_valid", b1.ex_valid, 1'b1);
    chk("first_ex_alu_src1", b1.ex_alu_src1, ALU_B_IMM);

    // Load-use with forwarding: lw $8 then add reading $8.
    instr1(1, 6'h23, 6'h00, 5'd29, 5'd8, 5'd0, 1, 0, 0, 1, 1);
    #1 chk("lw_in_id_no_stall", b1.stall, 1'b0);
    tick();
    instr1(1, 6'h00, 6'h20, 5'd8, 5'd10, 5'd11, 1, 1, 1, 1, 0);
    #1 chk("load_use_stall", b1.stall, 1'b1);
    tick();
    chk("load_use_bubble_valid", b1.ex_valid, 1'b0);
    chk("load_use_bubble_rw", b1.ex_reg_write, 1'b0);
    chk("load_use_bubble_funct", b1.ex_funct, 6'h0);
    chk("load_use_count", b1.bubble_count, 4'h1);
    chk("load_use_stall_released", b1.stall, 1'b0);
    tick();
    chk("add_lands_valid", b1.ex_valid, 1'b1);
    chk("add_lands_funct", b1.ex_funct, 6'h20);
    chk("add_lands_rd", b1.ex_rd, 5'd11);
    chk("add_lands_count", b1.bubble_count, 4'h1);

    // Flush and load-use hazard together.
    instr1(1, 6'h23, 6'h00, 5'd29, 5'd8, 5'd0, 1, 0, 0, 1, 1);
    #1 chk("add_in_ex_no_stall", b1.stall, 1'b0);
    tick();
    instr1(1, 6'h00, 6'h20, 5'd8, 5'd10, 5'd11, 1, 1, 1, 1, 0);
    b1.flush = 1'b1;
    #1 chk("flush_stall", b1.stall, 1'b0);
    tick();
    chk("flush_ex_valid", b1.ex_valid, 1'b0);
    chk("flush_count", b1.bubble_count, 4'h1);
    b1.flush = 1'b0;

    // Hold for three cycles with a live hazard.
    instr1(1, 6'h23, 6'h00, 5'd29, 5'd8, 5'd0, 1, 0, 0, 1, 1);
    tick();
    instr1(1, 6'h00, 6'h20, 5'd8, 5'd10, 5'd11, 1, 1, 1, 1, 0);
    b1.hold = 1'b1;
    #1 chk("hold_stall_pre", b1.stall, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_ex_opcode", b1.ex_opcode, 6'h23);
      chk("hold_ex_rt", b1.ex_rt, 5'd8);
      chk("hold_ex_valid", b1.ex_valid, 1'b1);
      chk("hold_count", b1.bubble_count, 4'h1);
      b1.id_rd = 5'(12 + i);
      b1.id_imm32b = 32'(i + 1);
      b1.id_alu_src1 = ALU_B_EIGHT;
      #1 chk("hold_stall", b1.stall, 1'b1);
    end
    b1.hold = 1'b0;

    // $0 producer never stalls its reader.
    instr1(1, 6'h23, 6'h00, 5'd0, 5'd0, 5'd0, 1, 0, 0, 1, 1);
    #1 chk("zero_lw_vs_lw8", b1.stall, 1'b0);
    tick();
    instr1(1, 6'h00, 6'h20, 5'd0, 5'd0, 5'd11, 1, 1, 1, 1, 0);
    #1 chk("zero_reg_no_stall", b1.stall, 1'b0);
    tick();

    // Reset asserted during a stall.
    instr1(1, 6'h23, 6'h00, 5'd29, 5'd8, 5'd0, 1, 0, 0, 1, 1);
    tick();
    instr1(1, 6'h00, 6'h20, 5'd8, 5'd10, 5'd11, 1, 1, 1, 1, 0);
    #1 chk("pre_reset_stall", b1.stall, 1'b1);
    rst = 1'b1;
    #1 chk("reset_masks_stall", b1.stall, 1'b0);
    tick();
    chk("mid_reset_ex_valid", b1.ex_valid, 1'b0);
    chk("mid_reset_ex_opcode", b1.ex_opcode, 6'h0);
    chk("mid_reset_count", b1.bubble_count, 4'h0);
    rst = 1'b0;
    #1 chk("post_reset_no_stall", b1.stall, 1'b0);

    // Saturation: self-dependent lw alternates load / bubble.
    instr1(1, 6'h23, 6'h00, 5'd8, 5'd8, 5'd0, 1, 0, 0, 1, 1);
    repeat (28) tick();
    chk("sat_count_14", b1.bubble_count, 4'he);
    repeat (2) tick();
    chk("sat_count_15", b1.bubble_count, 4'hf);
    tick();
    chk("sat_stall", b1.stall, 1'b1);
    tick();
    chk("sat_hold_f", b1.bubble_count, 4'hf);
    chk("sat_bubble_valid", b1.ex_valid, 1'b0);

    // No forwarding: add $9 then sub reading $9 via rt costs two bubbles.
    instr0(1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd9, 1, 1, 1, 1, 0);
    #1 chk("nf_add_no_stall", b0.stall, 1'b0);
    tick();
    instr0(1, 6'h00, 6'h22, 5'd3, 5'd9, 5'd10, 1, 1, 1, 1, 0);
    #1 chk("nf_raw_ex_stall", b0.stall, 1'b1);
    tick();
    chk("nf_bubble1_valid", b0.ex_valid, 1'b0);
    chk("nf_bubble1_count", b0.bubble_count, 32'd1);
    b0.mem_reg_write = 1'b1; b0.mem_dest = 5'd9;
    #1 chk("nf_raw_mem_stall", b0.stall, 1'b1);
    tick();
    chk("nf_bubble2_valid", b0.ex_valid, 1'b0);
    chk("nf_bubble2_count", b0.bubble_count, 32'd2);
    b0.mem_reg_write = 1'b0; b0.mem_dest = 5'd0;
    #1 chk("nf_wb_no_stall", b0.stall, 1'b0);
    tick();
    chk("nf_sub_valid", b0.ex_valid, 1'b1);
    chk("nf_sub_funct", b0.ex_funct, 6'h22);
    chk("nf_sub_rt", b0.ex_rt, 5'd9);
    chk("nf_sub_count", b0.bubble_count, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
